// File: rtl/led_scan_pkg.sv
// led_scan_pkg: state encoding, fixed latch/blank widths and a small helper shared by the
// LED scan engine and its timer.
package led_scan_pkg;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t StIdle    = 3'd0;
    localparam scan_state_t StShift   = 3'd1;
    localparam scan_state_t StLatch   = 3'd2;
    localparam scan_state_t StDisplay = 3'd3;
    localparam scan_state_t StBlank   = 3'd4;

    localparam int unsigned LE_CYCLES    = 2;
    localparam int unsigned BLANK_CYCLES = 4;

    // Used to size the shared timer to the largest interval it ever has to hold.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_engine_timer.sv
// led_scan_timer: loadable down-counter shared by every timed interval of the scan engine
// (dclk half-periods, le width, gclk pulse budget, blank gap). Holds at zero.
module led_scan_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_scan_engine.sv
// led_scan_engine: HUB75-style scan driver. Shifts one bit plane of one row into all chains,
// latches it, shows it for a binary-weighted number of gclk pulses, then moves on.
// Optional build macro LED_SCAN_BLANK_EN inserts an all-low gap after every DISPLAY.
module led_scan_engine
    import led_scan_pkg::*;
#(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned COLUMNS    = 112,
    parameter int unsigned ROWS       = 16,
    parameter int unsigned PIXEL_BITS = 8,
    parameter int unsigned BASE_TICKS = 1,
    parameter int unsigned DCLK_HALF  = 2,
    localparam int unsigned ROW_BITS  = $clog2(ROWS),
    localparam int unsigned COL_BITS  = $clog2(COLUMNS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    output logic [ROW_BITS+COL_BITS-1:0]   rd_addr,
    input  logic [CHANNELS*PIXEL_BITS-1:0] rd_data,
    output logic [CHANNELS-1:0]            sdo,
    output logic                           dclk,
    output logic                           le,
    output logic                           gclk,
    output logic [ROW_BITS-1:0]            row_addr,
    output logic                           frame_done
);

    localparam int unsigned PLANE_BITS = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam int unsigned GCLK_MAX   = BASE_TICKS << (PIXEL_BITS - 1);
    localparam int unsigned TIMER_MAX  =
        max_u(max_u(GCLK_MAX, DCLK_HALF), max_u(LE_CYCLES, BLANK_CYCLES));
    localparam int unsigned TW         = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0]         DCLK_RELOAD = TW'(DCLK_HALF - 1);
    localparam logic [TW-1:0]         LE_RELOAD   = TW'(LE_CYCLES - 1);
    localparam logic [COL_BITS-1:0]   COL_LAST    = COL_BITS'(COLUMNS - 1);
    localparam logic [ROW_BITS-1:0]   ROW_LAST    = ROW_BITS'(ROWS - 1);
    localparam logic [PLANE_BITS-1:0] PLANE_LAST  = PLANE_BITS'(PIXEL_BITS - 1);
`ifdef LED_SCAN_BLANK_EN
    localparam logic [TW-1:0]         BLANK_RELOAD = TW'(BLANK_CYCLES - 1);
`endif

    scan_state_t                   state_q, state_d;
    logic [ROW_BITS-1:0]           row_q, row_d;
    logic [PLANE_BITS-1:0]         plane_q, plane_d;
    logic [COL_BITS-1:0]           col_q, col_d;
    logic                          prime_q, prime_d;   // waiting for the first column's data
    logic                          last_q, last_d;     // final rising edge of this row-plane done
    logic                          dclk_q, dclk_d;
    logic                          le_q, le_d;
    logic                          gclk_q, gclk_d;
    logic [CHANNELS-1:0]           sdo_q, sdo_d;
    logic [ROW_BITS-1:0]           row_addr_q, row_addr_d;
    logic [ROW_BITS+COL_BITS-1:0]  rd_addr_q, rd_addr_d;

    logic                          t_load, t_dec, t_zero;
    logic [TW-1:0]                 t_val;
    logic                          begin_shift, go_idle, frame_end;
    logic [CHANNELS-1:0]           plane_sdo;

    led_scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (t_load),
        .load_val_i (t_val),
        .dec_i      (t_dec),
        .zero_o     (t_zero)
    );

    // Pick the current plane's bit out of each channel's pixel.
    always_comb begin
        plane_sdo = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            plane_sdo[ch] = rd_data[ch*PIXEL_BITS + int'(plane_q)];
        end
    end

    // Scan sequencer: next-state, output and timer control.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        plane_d     = plane_q;
        col_d       = col_q;
        prime_d     = prime_q;
        last_d      = last_q;
        dclk_d      = dclk_q;
        le_d        = le_q;
        gclk_d      = gclk_q;
        sdo_d       = sdo_q;
        row_addr_d  = row_addr_q;
        rd_addr_d   = rd_addr_q;
        t_load      = 1'b0;
        t_val       = '0;
        t_dec       = 1'b1;
        begin_shift = 1'b0;
        go_idle     = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    row_d       = '0;
                    plane_d     = '0;
                    begin_shift = 1'b1;
                end
            end
            StShift: begin
                if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = DCLK_RELOAD;
                    if (prime_q) begin
                        // First falling point: dclk is already low, just present the data.
                        sdo_d   = plane_sdo;
                        prime_d = 1'b0;
                    end else if (!dclk_q) begin
                        dclk_d = 1'b1;
                        if (col_q == COL_LAST) begin
                            last_d = 1'b1;
                        end else begin
                            // Fetch next column while dclk is high so data is ready at the fall.
                            col_d     = col_q + COL_BITS'(1);
                            rd_addr_d = {row_q, col_q + COL_BITS'(1)};
                        end
                    end else begin
                        dclk_d = 1'b0;
                        if (last_q) begin
                            state_d    = StLatch;
                            le_d       = 1'b1;
                            row_addr_d = row_q;
                            t_val      = LE_RELOAD;
                        end else begin
                            sdo_d = plane_sdo;
                        end
                    end
                end
            end
            StLatch: begin
                if (t_zero) begin
                    le_d    = 1'b0;
                    state_d = StDisplay;
                    t_load  = 1'b1;
                    t_val   = TW'((BASE_TICKS << plane_q) - 1);
                end
            end
            StDisplay: begin
                // Timer counts remaining gclk high phases, not clk cycles.
                t_dec = gclk_q;
                if (gclk_q && t_zero) begin
                    gclk_d = 1'b0;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            row_d = row_q + ROW_BITS'(1);
                        end
                    end else begin
                        plane_d = plane_q + PLANE_BITS'(1);
                    end
                    if (!enable) begin
                        go_idle = 1'b1;
                    end else begin
`ifdef LED_SCAN_BLANK_EN
                        state_d    = StBlank;
                        sdo_d      = '0;
                        rd_addr_d  = '0;
                        row_addr_d = '0;
                        t_load     = 1'b1;
                        t_val      = BLANK_RELOAD;
`else
                        begin_shift = 1'b1;
`endif
                    end
                end else begin
                    gclk_d = ~gclk_q;
                end
            end
            StBlank: begin
                if (t_zero) begin
                    if (enable) begin
                        begin_shift = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (begin_shift) begin
            state_d   = StShift;
            col_d     = '0;
            prime_d   = 1'b1;
            last_d    = 1'b0;
            dclk_d    = 1'b0;
            rd_addr_d = {row_d, {COL_BITS{1'b0}}};
            t_load    = 1'b1;
            t_val     = DCLK_RELOAD;
        end

        if (go_idle) begin
            state_d    = StIdle;
            row_d      = '0;
            plane_d    = '0;
            col_d      = '0;
            prime_d    = 1'b0;
            last_d     = 1'b0;
            dclk_d     = 1'b0;
            le_d       = 1'b0;
            gclk_d     = 1'b0;
            sdo_d      = '0;
            row_addr_d = '0;
            rd_addr_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            plane_q    <= '0;
            col_q      <= '0;
            prime_q    <= 1'b0;
            last_q     <= 1'b0;
            dclk_q     <= 1'b0;
            le_q       <= 1'b0;
            gclk_q     <= 1'b0;
            sdo_q      <= '0;
            row_addr_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            col_q      <= col_d;
            prime_q    <= prime_d;
            last_q     <= last_d;
            dclk_q     <= dclk_d;
            le_q       <= le_d;
            gclk_q     <= gclk_d;
            sdo_q      <= sdo_d;
            row_addr_q <= row_addr_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign sdo        = sdo_q;
    assign dclk       = dclk_q;
    assign le         = le_q;
    assign gclk       = gclk_q;
    assign row_addr   = row_addr_q;
    assign rd_addr    = rd_addr_q;
    // Decoded from registered state: high during the final DISPLAY cycle of a frame.
    assign frame_done = frame_end;

endmodule

// File: tb/tb_led_scan_engine.sv
// tb_led_scan_engine: directed bench for led_scan_engine with a 2-chain, 4-column, 2-row,
// 2-plane panel. Build with or without LED_SCAN_BLANK_EN to match the RTL.
module tb_led_scan_engine;

    localparam int unsigned CHANNELS   = 2;
    localparam int unsigned COLUMNS    = 4;
    localparam int unsigned ROWS       = 2;
    localparam int unsigned PIXEL_BITS = 2;
    localparam int unsigned BASE_TICKS = 1;
    localparam int unsigned DCLK_HALF  = 2;
    localparam int unsigned ROW_BITS   = 1;
    localparam int unsigned ADDR_BITS  = 3;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           enable;
    logic [ADDR_BITS-1:0]           rd_addr;
    logic [CHANNELS*PIXEL_BITS-1:0] rd_data;
    logic [CHANNELS-1:0]            sdo;
    logic                           dclk;
    logic                           le;
    logic                           gclk;
    logic [ROW_BITS-1:0]            row_addr;
    logic                           frame_done;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    logic [CHANNELS*PIXEL_BITS-1:0] mem [8];

    always #5 clk = ~clk;

    led_scan_engine #(
        .CHANNELS   (CHANNELS),
        .COLUMNS    (COLUMNS),
        .ROWS       (ROWS),
        .PIXEL_BITS (PIXEL_BITS),
        .BASE_TICKS (BASE_TICKS),
        .DCLK_HALF  (DCLK_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sdo        (sdo),
        .dclk       (dclk),
        .le         (le),
        .gclk       (gclk),
        .row_addr   (row_addr),
        .frame_done (frame_done)
    );

    // Pixel memory: every word is {ch1:2'b10, ch0:2'b01}, one-cycle read latency.
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'b1001;
    end
    always @(posedge clk) rd_data <= mem[rd_addr];

    // Invariants: le and gclk exclusive; dclk low whenever le or gclk is high.
    always @(negedge clk) begin
        if (!rst) begin
            if (le && gclk) viol <= viol + 1;
            if (dclk && (le || gclk)) viol <= viol + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit outs_zero();
        return ({sdo, dclk, le, gclk, row_addr, rd_addr, frame_done} == '0);
    endfunction

    task automatic do_reset(input logic en_after);
        enable = 1'b0;
        rst    = 1'b1;
        repeat (3) tick();
        rst    = 1'b0;
        enable = en_after;
    endtask

    // Observe one SHIFT/LATCH/DISPLAY segment starting from the current cycle.
    task automatic capture_seg(output int rises, output logic [1:0] s_or,
                               output logic [1:0] s_and, output logic [0:0] ra,
                               output int gcnt, output int fd, output bit ok);
        logic pd, pl, pg;
        bit   latched;
        rises = 0; s_or = '0; s_and = '1; ra = '0; gcnt = 0; fd = 0; ok = 0;
        pd = dclk; pl = le; pg = 1'b1; latched = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (frame_done) fd++;
            if (!latched) begin
                if (dclk && !pd) begin
                    rises++;
                    s_or  = s_or | sdo;
                    s_and = s_and & sdo;
                end
                if (le && !pl) begin
                    latched = 1;
                    ra      = row_addr;
                end
            end else if (le) begin
                pg = 1'b1;
            end else begin
                if (gclk && !pg) gcnt++;
                if (!gclk && !pg) begin
                    ok = 1;
                    break;
                end
                pg = gclk;
            end
            pd = dclk;
            pl = le;
        end
    endtask

    task automatic wait_le_rises(input int cnt, output bit ok);
        logic pl;
        int   seen;
        pl = le; seen = 0; ok = 0;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (le && !pl) seen++;
            pl = le;
            if (seen == cnt) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) tick();
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {sdo, dclk, le, gclk, row_addr, rd_addr, frame_done});
        end
        rst = 1'b0;
        enable = 1'b0;
        repeat (6) tick();
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL idle_disabled: got %b expected all zero",
                     {sdo, dclk, le, gclk, row_addr, rd_addr, frame_done});
        end
    endtask

    task automatic test_frame();
        int         rises, gcnt, fd, plane, exp_g, exp_fd;
        logic [1:0] s_or, s_and, exp_sdo;
        logic [0:0] ra, exp_ra;
        bit         ok;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            capture_seg(rises, s_or, s_and, ra, gcnt, fd, ok);
            plane   = k % 2;
            exp_sdo = (plane == 0) ? 2'b01 : 2'b10;
            exp_ra  = 1'((k / 2) % 2);
            exp_g   = 1 << plane;
            exp_fd  = (k == 3) ? 1 : 0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL frame seg%0d timeout: got no display end expected one", k);
            end
            checks++;
            if (rises !== 4) begin
                failures++;
                $display("FAIL frame seg%0d dclk_rises: got %0d expected 4", k, rises);
            end
            checks++;
            if ({s_or, s_and} !== {exp_sdo, exp_sdo}) begin
                failures++;
                $display("FAIL frame seg%0d sdo: got or=%b and=%b expected %b",
                         k, s_or, s_and, exp_sdo);
            end
            checks++;
            if (ra !== exp_ra) begin
                failures++;
                $display("FAIL frame seg%0d row_addr: got %0d expected %0d", k, ra, exp_ra);
            end
            checks++;
            if (gcnt !== exp_g) begin
                failures++;
                $display("FAIL frame seg%0d gclk_rises: got %0d expected %0d", k, gcnt, exp_g);
            end
            checks++;
            if (fd !== exp_fd) begin
                failures++;
                $display("FAIL frame seg%0d frame_done: got %0d expected %0d", k, fd, exp_fd);
            end
        end
    endtask

    task automatic test_enable_drop();
        int         rises, gcnt, fd, idle_bad;
        logic [1:0] s_or, s_and;
        logic [0:0] ra;
        bit         ok, ok2;
        do_reset(1'b1);
        capture_seg(rises, s_or, s_and, ra, gcnt, fd, ok);
        capture_seg(rises, s_or, s_and, ra, gcnt, fd, ok2);
        ok = ok && ok2;
        ok2 = 0;
        for (int n = 0; n < 100; n++) begin
            if (rd_addr[ADDR_BITS-1]) begin
                ok2 = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!(ok && ok2)) begin
            failures++;
            $display("FAIL drop_reach_row1: got ok=%0d expected 1", ok && ok2);
        end
        enable = 1'b0;
        capture_seg(rises, s_or, s_and, ra, gcnt, fd, ok);
        checks++;
        if ({ok, rises, ra, gcnt, fd} !== {1'b1, 32'd4, 1'b1, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL drop_last_seg: got ok=%0d rises=%0d row=%0d gclk=%0d fd=%0d expected 1 4 1 1 0",
                     ok, rises, ra, gcnt, fd);
        end
        checks++;
        if ({s_or, s_and} !== 4'b0101) begin
            failures++;
            $display("FAIL drop_sdo: got or=%b and=%b expected 01", s_or, s_and);
        end
        idle_bad = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!outs_zero()) idle_bad++;
        end
        checks++;
        if (idle_bad !== 0) begin
            failures++;
            $display("FAIL drop_idle: got %0d non-idle cycles expected 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_display();
        int         rises, gcnt, fd;
        logic [1:0] s_or, s_and;
        logic [0:0] ra;
        bit         ok;
        do_reset(1'b1);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (gclk) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_mid_reach_display: got no gclk expected gclk high");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL rst_mid_async: got %b expected all zero",
                     {sdo, dclk, le, gclk, row_addr, rd_addr, frame_done});
        end
        tick();
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL rst_mid_held: got %b expected all zero",
                     {sdo, dclk, le, gclk, row_addr, rd_addr, frame_done});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({rd_addr, dclk} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_first_addr: got addr=%0d dclk=%b expected 0 0", rd_addr, dclk);
        end
        capture_seg(rises, s_or, s_and, ra, gcnt, fd, ok);
        checks++;
        if ({ok, rises, ra, gcnt, s_or, s_and} !== {1'b1, 32'd4, 1'b0, 32'd1, 4'b0101}) begin
            failures++;
            $display("FAIL rst_mid_restart: got ok=%0d rises=%0d row=%0d gclk=%0d sdo=%b expected 1 4 0 1 01",
                     ok, rises, ra, gcnt, s_or);
        end
    endtask

    task automatic test_blank_gap();
        bit ok, seen_hi, zero_run;
        int gap_dclk, gap_zero, exp_dclk, exp_zero;
`ifdef LED_SCAN_BLANK_EN
        exp_dclk = 8;
        exp_zero = 4;
`else
        exp_dclk = 4;
        exp_zero = 0;
`endif
        do_reset(1'b1);
        wait_le_rises(2, ok);
        seen_hi = 0; zero_run = 0; gap_dclk = 0; gap_zero = 0;
        if (ok) begin
            ok = 0;
            for (int n = 0; n < 200; n++) begin
                tick();
                if (gclk) begin
                    seen_hi = 1; gap_dclk = 0; gap_zero = 0; zero_run = 1;
                end else if (seen_hi) begin
                    if (dclk) begin
                        ok = 1;
                        break;
                    end
                    gap_dclk++;
                    if (zero_run && outs_zero()) gap_zero++;
                    else zero_run = 0;
                end
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL gap_timeout: got no next dclk edge expected one");
        end
        checks++;
        if (gap_dclk !== exp_dclk) begin
            failures++;
            $display("FAIL gap_dclk_cycles: got %0d expected %0d", gap_dclk, exp_dclk);
        end
        checks++;
        if (gap_zero !== exp_zero) begin
            failures++;
            $display("FAIL gap_all_low_cycles: got %0d expected %0d", gap_zero, exp_zero);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL invariants: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        test_reset();
        test_frame();
        test_enable_drop();
        test_reset_mid_display();
        test_blank_gap();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scan_engine.md
LED_SCAN_ENGINE -- requirements
Module: led_scan_engine

Interface
REQ-001 Parameter CHANNELS, default 3: number of panel chains driven in parallel.
REQ-002 Parameter COLUMNS, default 112: bits shifted per chain per row-plane.
REQ-003 Parameter ROWS, default 16: multiplexed rows, power of two; ROW_BITS = log2(ROWS).
REQ-004 Parameter PIXEL_BITS, default 8: bit planes per pixel (binary-coded modulation).
REQ-005 Parameter BASE_TICKS, default 1: gclk pulses for plane 0.
REQ-006 Parameter DCLK_HALF, default 2, minimum 2: dclk half-period in clk cycles.
REQ-007 clk  in  1  system clock; the only clock.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 enable  in  1  run scanning while high.
REQ-010 rd_addr  out  ROW_BITS+log2(COLUMNS)  pixel word address {row, column}.
REQ-011 rd_data  in  CHANNELS*PIXEL_BITS  pixel word, valid exactly 1 cycle after rd_addr.
REQ-012 sdo  out  CHANNELS  serial data per chain.
REQ-013 dclk  out  1  shift clock shared by all chains; panels sample on rising edge.
REQ-014 le  out  1  latch enable.
REQ-015 gclk  out  1  grayscale clock.
REQ-016 row_addr  out  ROW_BITS  row select (drives A..D pins).
REQ-017 frame_done  out  1  one-cycle pulse at end of each frame.

Function
REQ-018 States: IDLE, SHIFT, LATCH, DISPLAY, BLANK; scan order: row 0..ROWS-1 outer, plane 0..PIXEL_BITS-1 inner.
REQ-019 IDLE -> SHIFT when enable=1; row=0, plane=0.
REQ-020 SHIFT: per column c, rd_addr={row,c} driven one cycle before dclk falls; sdo[ch] <= rd_data[ch*PIXEL_BITS+plane] on the dclk falling cycle; dclk rises DCLK_HALF cycles later; exactly COLUMNS rising edges, then dclk held low.
REQ-021 LATCH: le high for 2 cycles with dclk and gclk low; row_addr <= row on LATCH entry; then DISPLAY.
REQ-022 DISPLAY: gclk toggles every clk, starting low, for exactly BASE_TICKS<<plane rising edges, ends low.
REQ-023 After DISPLAY: advance plane; on plane wrap advance row; on row wrap pulse frame_done in the same cycle DISPLAY exits and restart at row 0.
REQ-024 enable deasserted mid-operation: current DISPLAY (or SHIFT+LATCH+DISPLAY) completes, then IDLE with all outputs low; frame_done not pulsed unless the frame was completed.
REQ-025 Counter widths sized from parameters; gclk counter holds BASE_TICKS<<(PIXEL_BITS-1) without overflow.
REQ-026 le and gclk never high in the same cycle; dclk never toggles during LATCH or DISPLAY.

Reset
REQ-027 On rst: state IDLE; sdo, dclk, le, gclk, row_addr, rd_addr, frame_done all 0; row/plane counters 0.
REQ-028 rst mid-frame aborts immediately; scanning restarts at row 0, plane 0 after release if enable=1.

Configuration
REQ-029 LED_SCAN_BLANK_EN defined: BLANK state of 4 cycles, all outputs low, inserted after every DISPLAY before the next SHIFT; undefined: BLANK never entered, DISPLAY goes directly to SHIFT.

Structure
REQ-030 Package led_scan_pkg holds the state enum and the LE_CYCLES=2 and BLANK_CYCLES=4 constants.
REQ-031 Sub-module led_scan_timer: loadable down-counter used for dclk half-periods, le width, gclk pulse count and blank gap.

Verification (CHANNELS=2, COLUMNS=4, ROWS=2, PIXEL_BITS=2, BASE_TICKS=1, DCLK_HALF=2)
REQ-032 Memory word at {r,c} = {ch1:2'b10, ch0:2'b01}; plane 0 -> sdo=2'b01 on all 4 dclk edges, plane 1 -> sdo=2'b10.
REQ-033 Count gclk rising edges per DISPLAY -> 1, 2, 1, 2; row_addr 0,0,1,1; frame_done pulses once after the 4th DISPLAY.
REQ-034 Drop enable during row 1 plane 0 SHIFT -> that LATCH/DISPLAY completes, then IDLE, no frame_done.
REQ-035 Assert rst mid-DISPLAY -> all outputs 0 next cycle; after release first rd_addr = {0,0}.
REQ-036 Build with and without LED_SCAN_BLANK_EN -> 4 all-low cycles between DISPLAY end and next rd_addr only when defined.
REQ-037 Assertions throughout: le&gclk never 1; dclk static outside SHIFT; exactly 4 dclk rising edges per SHIFT.
